// File: rtl/gifplayer_soc_otg_hpi_in.sv
// Avalon-MM input PIO for CY7C67200 HPI status pins: 2-FF sync, optional glitch filter,
// sticky edge capture, maskable registered irq. Optional filter: OTG_HPI_IN_GLITCH_FILTER_EN.
module gifplayer_soc_otg_hpi_in #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned EDGE_TYPE     = 0,
  parameter logic [31:0] RESET_VALUE   = '0,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RstVal = RESET_VALUE[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > 32 || FILTER_CYCLES < 2 || FILTER_CYCLES > 255) begin : g_bad_param
    $error("gifplayer_soc_otg_hpi_in: parameter out of range");
  end

  logic [WIDTH-1:0] meta_q, sync_q, filt, prev_q, edge_det;
  logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, clr;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             rd_en, wr_en;
  logic             unused_wd;

  assign unused_wd = &{1'b0, writedata};
  assign rd_en     = chipselect & ~read_n;
  assign wr_en     = chipselect & ~write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RstVal;
      sync_q <= RstVal;
    end else begin
      meta_q <= in_port;
      sync_q <= meta_q;
    end
  end

`ifdef OTG_HPI_IN_GLITCH_FILTER_EN
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [7:0]       cnt_q [WIDTH];
  logic [7:0]       cnt_d [WIDTH];

  // Counter runs while sync disagrees with filt; filt follows only after
  // FILTER_CYCLES consecutive disagreeing cycles, and any agreement restarts it.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != filt_q[i]) begin
        if (cnt_q[i] >= 8'(FILTER_CYCLES - 1)) begin
          filt_d[i] = sync_q[i];
        end else if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= RstVal;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= RstVal;
    else          prev_q <= filt;
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = filt & ~prev_q;
      1:       edge_det = ~filt & prev_q;
      default: edge_det = filt ^ prev_q;
    endcase
  end

  always_comb begin
    mask_d  = mask_q;
    clr     = '0;
    rdata_d = '0;
    if (wr_en && address == 2'd2) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) clr    = writedata[WIDTH-1:0];
    // A new edge in the same cycle as a clear keeps the bit set.
    cap_d = (cap_q & ~clr) | edge_det;
    irq_d = |(cap_q & mask_q);
    case (address)
      2'd0:    rdata_d[WIDTH-1:0] = filt;
      2'd2:    rdata_d[WIDTH-1:0] = mask_q;
      2'd3:    rdata_d[WIDTH-1:0] = cap_q;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cap_q  <= cap_d;
      irq_q  <= irq_d;
      if (rd_en) rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gifplayer_soc_otg_hpi_in.sv
// Scoreboard bench: stimulus queues expected read/irq values, a negedge monitor pops and compares.
module tb_gifplayer_soc_otg_hpi_in;

  localparam int unsigned FC = 4;
`ifdef OTG_HPI_IN_GLITCH_FILTER_EN
  localparam int unsigned FLT = FC;
`else
  localparam int unsigned FLT = 0;
`endif

  logic        clk, reset_n;
  logic [1:0]  address;
  logic        read_n, write_n, cs_a, cs_b;
  logic [31:0] writedata;
  logic [0:0]  in_a;
  logic [15:0] in_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  gifplayer_soc_otg_hpi_in #(.WIDTH(1), .EDGE_TYPE(0), .RESET_VALUE(32'h0), .FILTER_CYCLES(FC)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a), .read_n(read_n),
    .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

  gifplayer_soc_otg_hpi_in #(.WIDTH(16), .EDGE_TYPE(2), .RESET_VALUE(32'h0), .FILTER_CYCLES(FC)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b), .read_n(read_n),
    .write_n(write_n), .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          on_b;
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rd_tk_a = 1'b0, rd_tk_b = 1'b0, irq_pq = 1'b0, probe_b_q = 1'b0;
  logic irq_probe = 1'b0, probe_b = 1'b0;

  always @(posedge clk) begin
    rd_tk_a   <= cs_a & ~read_n;
    rd_tk_b   <= cs_b & ~read_n;
    irq_pq    <= irq_probe;
    probe_b_q <= probe_b;
  end

  task automatic check_evt(input bit is_irq, input bit on_b);
    exp_t        e;
    logic [31:0] act;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: irq=%0d dut_b=%0d with nothing expected", is_irq, on_b);
      return;
    end
    e   = sb.pop_front();
    act = is_irq ? {31'b0, (on_b ? irq_b : irq_a)} : (on_b ? rd_b : rd_a);
    if (e.is_irq != is_irq || e.on_b != on_b || act !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_tk_a || rd_tk_b) check_evt(1'b0, rd_tk_b);
    if (irq_pq)             check_evt(1'b1, probe_b_q);
  end

  task automatic push(input bit b, input bit is_irq, input logic [31:0] exp, input string nm);
    exp_t e;
    e.on_b = b; e.is_irq = is_irq; e.exp = exp; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic bus_idle();
    cs_a = 1'b0; cs_b = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit b, input logic [1:0] a, input logic [31:0] d);
    cs_a = !b; cs_b = b; address = a; writedata = d; write_n = 1'b0;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input bit b, input logic [1:0] a, input logic [31:0] exp, input string nm);
    push(b, 1'b0, exp, nm);
    cs_a = !b; cs_b = b; address = a; read_n = 1'b0;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rw(input bit b, input logic [1:0] a, input logic [31:0] d,
                    input logic [31:0] exp, input string nm);
    push(b, 1'b0, exp, nm);
    cs_a = !b; cs_b = b; address = a; writedata = d; read_n = 1'b0; write_n = 1'b0;
    @(negedge clk);
    bus_idle();
  endtask

  // Checks irq as it stands after the next rising edge.
  task automatic probe(input bit b, input logic exp, input string nm);
    push(b, 1'b1, {31'b0, exp}, nm);
    irq_probe = 1'b1; probe_b = b;
    @(negedge clk);
    irq_probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; bus_idle(); address = '0; writedata = '0; in_a = '0; in_b = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Traffic, then reset mid-operation
    wr(0, 2'd2, 32'h1);
    wr(1, 2'd2, 32'hFFFF);
    in_a = 1'b1; in_b = 16'h0005;
    tick(10);
    reset_n = 1'b0;
    in_a = 1'b0; in_b = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      rd(0, 2'(i), 32'h0, $sformatf("reset_a_addr%0d", i));
      rd(1, 2'(i), 32'h0, $sformatf("reset_b_addr%0d", i));
    end
    probe(0, 1'b0, "reset_irq_a");
    probe(1, 1'b0, "reset_irq_b");

    // Rising capture with irq latency
    wr(0, 2'd2, 32'h1);
    rd(0, 2'd2, 32'h1, "mask_readback");
    in_a = 1'b1;
    tick(2 + FLT);
    probe(0, 1'b0, "irq_before_latency");
    probe(0, 1'b1, "irq_at_latency");
    rd(0, 2'd3, 32'h1, "rise_captured");
    rd(0, 2'd0, 32'h1, "data_high");
    wr(0, 2'd3, 32'h1);
    probe(0, 1'b0, "irq_after_clear");
    rd(0, 2'd3, 32'h0, "cap_cleared");

    // Masked capture; falling edge ignored for rising type
    wr(0, 2'd2, 32'h0);
    in_a = 1'b0;
    tick(8 + FLT);
    rd(0, 2'd3, 32'h0, "falling_ignored");
    in_a = 1'b1;
    tick(8 + FLT);
    rd(0, 2'd3, 32'h1, "masked_capture");
    probe(0, 1'b0, "masked_irq_low");
    wr(0, 2'd2, 32'h1);
    probe(0, 1'b1, "unmask_irq");

    // Set beats clear
    wr(0, 2'd3, 32'h1);
    in_a = 1'b0;
    tick(8 + FLT);
    rd(0, 2'd3, 32'h0, "pre_sbc_clear");
    in_a = 1'b1;
    tick(2 + FLT);
    wr(0, 2'd3, 32'h1);
    tick(2);
    rd(0, 2'd3, 32'h1, "set_beats_clear");

    // Read and write same cycle returns pre-write value
    rw(0, 2'd2, 32'h0, 32'h1, "rw_prewrite");
    rd(0, 2'd2, 32'h0, "rw_written");

    // Any-edge, 16 bits
    in_b = 16'h00F0;
    tick(10 + FLT);
    in_b = 16'h0030;
    tick(10 + FLT);
    rd(1, 2'd3, 32'h0000_00F0, "any_edge_cap");
    rd(1, 2'd0, 32'h0000_0030, "b_data");
    wr(1, 2'd3, 32'hFFFF_0000);
    rd(1, 2'd3, 32'h0000_00F0, "upper_clear_ignored");
    wr(1, 2'd3, 32'h0000_0010);
    rd(1, 2'd3, 32'h0000_00E0, "partial_clear");
    wr(1, 2'd0, 32'h0000_FFFF);
    rd(1, 2'd0, 32'h0000_0030, "data_write_ignored");
    wr(1, 2'd1, 32'hFFFF_FFFF);
    rd(1, 2'd1, 32'h0, "reserved_zero");
    wr(1, 2'd2, 32'hFFFF_FFFF);
    rd(1, 2'd2, 32'h0000_FFFF, "mask_width_limited");
    probe(1, 1'b1, "irq_b_high");

    // Short pulses versus the glitch filter
    in_a = 1'b0;
    tick(10 + FLT);
    wr(0, 2'd3, 32'h1);
    rd(0, 2'd3, 32'h0, "pre_pulse_clear");
    in_a = 1'b1;
    tick(3);
    in_a = 1'b0;
    tick(12 + FLT);
    rd(0, 2'd0, 32'h0, "pulse3_data");
    rd(0, 2'd3, (FLT != 0) ? 32'h0 : 32'h1, "pulse3_cap");
    wr(0, 2'd3, 32'h1);
    rd(0, 2'd3, 32'h0, "pulse_clear");
    in_a = 1'b1;
    tick(4);
    in_a = 1'b0;
    tick(12 + FLT);
    rd(0, 2'd3, 32'h1, "pulse4_cap");

    tick(3);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
